seq_serializer: RTL and testbench

Upstream feeder for the Mealy overlapping `1010` sequence detector. It accepts parallel words over a valid/ready handshake and emits them as a continuous serial bit stream on `x`, one bit per clock. A one-word holding buffer lets back-to-back words stream with no idle bubble between frames. `x_valid` qualifies the stream, and `sof` marks the first bit of each word.

---
 rtl/seq_serializer.sv | 101 ++++++++++
 tb/tb_seq_serializer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder with a one-word holding buffer for gapless back-to-back frames.
// Build option: define SERIALIZER_LSB_FIRST_EN for LSB-first output (MSB-first otherwise).
module seq_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             sof,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] hbuf;
    logic [CW-1:0]    cnt;
    logic             hfull;
    logic             accept;

`ifdef SERIALIZER_LSB_FIRST_EN
    function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] v);
        return {1'b0, v[WIDTH-1:1]};
    endfunction

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return v[0];
    endfunction
`else
    function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return v[WIDTH-1];
    endfunction
`endif

    // Ready depends only on the buffer flag, never on din_valid.
    assign din_ready = !hfull;
    assign accept    = din_valid && !hfull;

    assign x_valid = (state == SHIFT);
    assign x       = (state == SHIFT) && head_bit(sh);
    assign sof     = (state == SHIFT) && (cnt == '0);
    assign busy    = (state == SHIFT) || hfull;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sh    <= '0;
            hbuf  <= '0;
            cnt   <= '0;
            hfull <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hfull <= 1'b0;
                    if (accept) begin
                        sh    <= din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        sh  <= shift_next(sh);
                        cnt <= cnt + CW'(1);
                        if (accept) begin
                            hbuf  <= din;
                            hfull <= 1'b1;
                        end
                    end else if (hfull) begin
                        // Buffered word takes priority; ready was low, so no new accept here.
                        sh    <= hbuf;
                        hfull <= 1'b0;
                        cnt   <= '0;
                    end else if (accept) begin
                        sh  <= din;
                        cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: reset, single word, back-to-back, backpressure,
// reset mid-word, idle gap and (when SERIALIZER_LSB_FIRST_EN is defined) LSB-first order.
module tb_seq_serializer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             sof;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_serializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .sof       (sof),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Word as it appears on x, first emitted bit at the MSB of the result.
    function automatic logic [7:0] emit_order(input logic [7:0] w);
        logic [7:0] r;
`ifdef SERIALIZER_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = w[i];
`else
        r = w;
`endif
        return r;
    endfunction

    task automatic collect(input int n, output logic [31:0] bits,
                           output logic [31:0] sofs, output int nv);
        bits = '0;
        sofs = '0;
        nv   = 0;
        for (int i = 0; i < n; i++) begin
            bits = {bits[30:0], x};
            sofs = {sofs[30:0], sof};
            if (x_valid === 1'b1) nv++;
            step();
        end
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        step();
        step();
        n_checks++;
        if ({x, x_valid, sof, busy, din_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_outputs: got x/xv/sof/busy/rdy=%b expected %b",
                     {x, x_valid, sof, busy, din_ready}, 5'b00001);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({x_valid, busy, din_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_release_idle: got xv/busy/rdy=%b expected %b",
                     {x_valid, busy, din_ready}, 3'b001);
        end
    endtask

    task automatic test_single_word;
        logic [31:0] bits, sofs;
        int          nv;
        logic [7:0]  exp_bits;
`ifdef SERIALIZER_LSB_FIRST_EN
        exp_bits = 8'b0101_0101;
`else
        exp_bits = 8'b1010_1010;
`endif
        din       = 8'hAA;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        collect(8, bits, sofs, nv);
        n_checks++;
        if (bits[7:0] !== exp_bits) begin
            n_fail++;
            $display("FAIL single_bits: got %b expected %b", bits[7:0], exp_bits);
        end
        n_checks++;
        if (sofs[7:0] !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL single_sof: got %b expected %b", sofs[7:0], 8'b1000_0000);
        end
        n_checks++;
        if (nv != 8) begin
            n_fail++;
            $display("FAIL single_valid_count: got %0d expected 8", nv);
        end
        n_checks++;
        if ({x_valid, x, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_after: got xv/x/busy=%b expected 000", {x_valid, x, busy});
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] bits, sofs, rdy, exp_bits;
        int          nv;
        bits = '0; sofs = '0; rdy = '0; nv = 0;
        exp_bits = {emit_order(8'hA5), emit_order(8'h5A)};
        din       = 8'hA5;
        din_valid = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            bits = {bits[14:0], x};
            sofs = {sofs[14:0], sof};
            rdy  = {rdy[14:0], din_ready};
            if (x_valid === 1'b1) nv++;
            if (i == 0) din = 8'h5A;
            step();
            if (i == 0) din_valid = 1'b0;
        end
        n_checks++;
        if (bits !== exp_bits) begin
            n_fail++;
            $display("FAIL b2b_bits: got %b expected %b", bits, exp_bits);
        end
        n_checks++;
        if (sofs !== 16'b1000_0000_1000_0000) begin
            n_fail++;
            $display("FAIL b2b_sof: got %b expected %b", sofs, 16'b1000_0000_1000_0000);
        end
        n_checks++;
        if (nv != 16) begin
            n_fail++;
            $display("FAIL b2b_contiguous: got %0d valid cycles expected 16", nv);
        end
        n_checks++;
        if (rdy !== 16'b1000_0000_1111_1111) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b expected %b", rdy, 16'b1000_0000_1111_1111);
        end
        n_checks++;
        if ({x_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_after: got xv/busy=%b expected 00", {x_valid, busy});
        end
    endtask

    task automatic test_backpressure;
        logic [7:0]  words [3];
        int          acc_edge [3];
        logic [23:0] stream, sofs, exp_stream;
        int          nbits, idx;
        logic        acc;
        words[0] = 8'hC3; words[1] = 8'h96; words[2] = 8'h7E;
        acc_edge[0] = -1; acc_edge[1] = -1; acc_edge[2] = -1;
        exp_stream = {emit_order(words[0]), emit_order(words[1]), emit_order(words[2])};
        stream = '0; sofs = '0; nbits = 0; idx = 0;
        din       = words[0];
        din_valid = 1'b1;
        for (int e = 0; e < 26; e++) begin
            acc = din_valid && din_ready;
            if (x_valid === 1'b1) begin
                stream = {stream[22:0], x};
                sofs   = {sofs[22:0], sof};
                nbits++;
            end
            step();
            if (acc) begin
                acc_edge[idx] = e;
                idx++;
                if (idx < 3) din = words[idx];
                else din_valid = 1'b0;
            end
        end
        din_valid = 1'b0;
        n_checks++;
        if (nbits != 24) begin
            n_fail++;
            $display("FAIL bp_bit_count: got %0d expected 24", nbits);
        end
        n_checks++;
        if (stream !== exp_stream) begin
            n_fail++;
            $display("FAIL bp_scoreboard: got %h expected %h", stream, exp_stream);
        end
        n_checks++;
        if (sofs !== 24'h808080) begin
            n_fail++;
            $display("FAIL bp_sof: got %h expected %h", sofs, 24'h808080);
        end
        n_checks++;
        if (acc_edge[0] != 0 || acc_edge[1] != 1 || acc_edge[2] != 9) begin
            n_fail++;
            $display("FAIL bp_accept_edges: got %0d,%0d,%0d expected 0,1,9",
                     acc_edge[0], acc_edge[1], acc_edge[2]);
        end
        n_checks++;
        if ({x_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_after: got xv/busy=%b expected 00", {x_valid, busy});
        end
    endtask

    task automatic test_reset_mid_word;
        logic [31:0] bits, sofs;
        int          nv;
        logic [9:0]  exp_bits;
        exp_bits = {emit_order(8'h0F), 2'b00};
        din       = 8'hF0;
        din_valid = 1'b1;
        step();
        din = 8'h3C;
        step();
        din_valid = 1'b0;
        step();
        step();
        n_checks++;
        if ({busy, din_ready, x_valid} !== 3'b101) begin
            n_fail++;
            $display("FAIL mid_before_reset: got busy/rdy/xv=%b expected 101",
                     {busy, din_ready, x_valid});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({x, x_valid, sof, busy, din_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL mid_reset_immediate: got x/xv/sof/busy/rdy=%b expected 00001",
                     {x, x_valid, sof, busy, din_ready});
        end
        step();
        step();
        rst = 1'b1;
        din       = 8'h0F;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        collect(10, bits, sofs, nv);
        n_checks++;
        if (bits[9:0] !== exp_bits) begin
            n_fail++;
            $display("FAIL mid_after_bits: got %b expected %b", bits[9:0], exp_bits);
        end
        n_checks++;
        if (nv != 8 || sofs[9:0] !== 10'b10_0000_0000) begin
            n_fail++;
            $display("FAIL mid_after_frame: got valid=%0d sof=%b expected 8 and %b",
                     nv, sofs[9:0], 10'b10_0000_0000);
        end
    endtask

    task automatic test_idle_gap;
        logic [31:0] bits, sofs;
        int          nv;
        logic [7:0]  exp_cc;
        exp_cc    = emit_order(8'hCC);
        din       = 8'hAA;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        collect(8, bits, sofs, nv);
        n_checks++;
        if (bits[7:0] !== emit_order(8'hAA)) begin
            n_fail++;
            $display("FAIL gap_first_word: got %b expected %b", bits[7:0], emit_order(8'hAA));
        end
        collect(5, bits, sofs, nv);
        n_checks++;
        if (nv != 0 || bits[4:0] !== 5'b00000) begin
            n_fail++;
            $display("FAIL gap_idle: got valid=%0d x=%b expected 0 and 00000", nv, bits[4:0]);
        end
        din       = 8'hCC;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        n_checks++;
        if ({sof, x_valid, x} !== {2'b11, exp_cc[7]}) begin
            n_fail++;
            $display("FAIL gap_latency: got sof/xv/x=%b expected %b",
                     {sof, x_valid, x}, {2'b11, exp_cc[7]});
        end
        collect(8, bits, sofs, nv);
        n_checks++;
        if (bits[7:0] !== exp_cc || nv != 8) begin
            n_fail++;
            $display("FAIL gap_second_word: got %b valid=%0d expected %b valid=8",
                     bits[7:0], nv, exp_cc);
        end
    endtask

`ifdef SERIALIZER_LSB_FIRST_EN
    task automatic test_lsb_first;
        logic [31:0] bits, sofs;
        int          nv;
        din       = 8'h0A;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        collect(8, bits, sofs, nv);
        n_checks++;
        if (bits[7:0] !== 8'b0101_0000 || sofs[7:0] !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL lsb_order: got x=%b sof=%b expected %b and %b",
                     bits[7:0], sofs[7:0], 8'b0101_0000, 8'b1000_0000);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_idle_gap();
`ifdef SERIALIZER_LSB_FIRST_EN
        test_lsb_first();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
